pipeline_hazard_ctrl: RTL and testbench

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

---
 rtl/pipeline_hazard_ctrl_pkg.sv | 30 +++
 rtl/pipeline_hazard_ctrl_fwd_unit.sv | 37 +++
 rtl/pipeline_hazard_ctrl.sv | 179 +++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: control FSM state
// encodings, forwarding selects, the load writeback select, the NOP
// instruction word and a saturating counter helper.
package pipeline_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } hz_state_e;

    localparam logic [1:0]  FWD_RF       = 2'b00;
    localparam logic [1:0]  FWD_M        = 2'b01;
    localparam logic [1:0]  FWD_W        = 2'b10;
    localparam logic [1:0]  WB_MEM       = 2'b01;
    localparam logic [31:0] NOP_WORD     = 32'h0000_0013;
    localparam logic [1:0]  DRAIN_CYCLES = 2'd3;

    // Increment by one when enabled, sticking at all-ones.
    function automatic logic [15:0] sat_inc(input logic [15:0] val, input logic en);
        logic [15:0] res;
        if (en && (val != 16'hFFFF)) begin
            res = val + 16'd1;
        end else begin
            res = val;
        end
        return res;
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_fwd_unit.sv
// fwd_unit: selects the source of one execute-stage operand.
// Ports:
//   rs_i                 execute-stage source register index
//   rdst_m_i, wen_m_n_i  memory-stage destination and active-low write enable
//   rdst_w_i, wen_w_n_i  writeback-stage destination and active-low write enable
//   sel_o                FWD_RF / FWD_M / FWD_W
module fwd_unit
    import pipeline_hazard_ctrl_pkg::*;
(
    input  logic [4:0] rs_i,
    input  logic [4:0] rdst_m_i,
    input  logic       wen_m_n_i,
    input  logic [4:0] rdst_w_i,
    input  logic       wen_w_n_i,
    output logic [1:0] sel_o
);

    logic hit_m_s;
    logic hit_w_s;

    // x0 is hard-wired zero, so a write to it never produces a forward.
    assign hit_m_s = !wen_m_n_i && (rdst_m_i != 5'd0) && (rdst_m_i == rs_i);
    assign hit_w_s = !wen_w_n_i && (rdst_w_i != 5'd0) && (rdst_w_i == rs_i);

    // The younger result in M shadows the older one in W.
    always_comb begin
        sel_o = FWD_RF;
        if (hit_m_s) begin
            sel_o = FWD_M;
        end else if (hit_w_s) begin
            sel_o = FWD_W;
        end else begin
            sel_o = FWD_RF;
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: load-use stall, branch flush, operand forwarding and
// halt draining for a five-stage pipeline. State changes on the falling clock
// edge to line up with the pipeline registers.
// Ports:
//   CLK, RST                        clock, async active-high reset
//   Rs1_D/Rs2_D, Rs1_E/Rs2_E        source indices in decode / execute
//   Rdst_E/M/W, RegWrEn_E/M/W       destinations and active-low write enables
//   WBSel_E, BranchTaken_E, halt_D  load detect, taken branch, halt in decode
//   stall_F/D/E, nop_D/E            pipeline hold / bubble controls
//   FwdA_E, FwdB_E                  operand forwarding selects
//   Halted, StallCount, FlushCount  drained flag and saturating event counters
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
(
    input  logic        CLK,
    input  logic        RST,
    input  logic [4:0]  Rs1_D,
    input  logic [4:0]  Rs2_D,
    input  logic [4:0]  Rs1_E,
    input  logic [4:0]  Rs2_E,
    input  logic [4:0]  Rdst_E,
    input  logic [4:0]  Rdst_M,
    input  logic [4:0]  Rdst_W,
    input  logic        RegWrEn_E,
    input  logic        RegWrEn_M,
    input  logic        RegWrEn_W,
    input  logic [1:0]  WBSel_E,
    input  logic        BranchTaken_E,
    input  logic        halt_D,
    output logic        stall_F,
    output logic        stall_D,
    output logic        stall_E,
    output logic        nop_D,
    output logic        nop_E,
    output logic [1:0]  FwdA_E,
    output logic [1:0]  FwdB_E,
    output logic        Halted,
    output logic [15:0] StallCount,
    output logic [15:0] FlushCount
);

    hz_state_e   state_q, state_d;
    logic [1:0]  drain_cnt_q, drain_cnt_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic [15:0] flush_cnt_q, flush_cnt_d;
    logic        load_hit_s;
    logic        load_use_s;
    logic        flush_s;
    logic [1:0]  fwd_a_s;
    logic [1:0]  fwd_b_s;

    // A load in E whose target is read in D; only acted on while running and
    // not overridden by a flush (decode holds a NOP while draining).
    assign load_hit_s = (WBSel_E == WB_MEM) && !RegWrEn_E && (Rdst_E != 5'd0) &&
                        ((Rdst_E == Rs1_D) || (Rdst_E == Rs2_D));
    assign load_use_s = load_hit_s && (state_q == ST_RUN) && !BranchTaken_E;
    // Once halted the pipeline is frozen, so a branch no longer flushes.
    assign flush_s    = BranchTaken_E && (state_q != ST_HALTED);

    fwd_unit u_fwd_a (
        .rs_i      (Rs1_E),
        .rdst_m_i  (Rdst_M),
        .wen_m_n_i (RegWrEn_M),
        .rdst_w_i  (Rdst_W),
        .wen_w_n_i (RegWrEn_W),
        .sel_o     (fwd_a_s)
    );

    fwd_unit u_fwd_b (
        .rs_i      (Rs2_E),
        .rdst_m_i  (Rdst_M),
        .wen_m_n_i (RegWrEn_M),
        .rdst_w_i  (Rdst_W),
        .wen_w_n_i (RegWrEn_W),
        .sel_o     (fwd_b_s)
    );

    // State, drain counter and event counter registers.
    always_ff @(negedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= ST_RUN;
            drain_cnt_q <= 2'd0;
            stall_cnt_q <= 16'd0;
            flush_cnt_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // Next-state logic for the halt FSM and the event counters.
    always_comb begin
        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        stall_cnt_d = sat_inc(stall_cnt_q, load_use_s);
        flush_cnt_d = sat_inc(flush_cnt_q, flush_s);
        case (state_q)
            ST_RUN: begin
                if (BranchTaken_E) begin
                    drain_cnt_d = 2'd0;
                end else if (load_use_s) begin
                    // halt_D is stalled in decode; it is re-presented next cycle.
                    state_d = ST_RUN;
                end else if (halt_D) begin
                    state_d     = ST_DRAIN;
                    drain_cnt_d = DRAIN_CYCLES;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (BranchTaken_E) begin
                    // The halt was on the wrong path.
                    state_d     = ST_RUN;
                    drain_cnt_d = 2'd0;
                end else if (drain_cnt_q <= 2'd1) begin
                    state_d     = ST_HALTED;
                    drain_cnt_d = 2'd0;
                end else begin
                    drain_cnt_d = drain_cnt_q - 2'd1;
                end
            end
            ST_HALTED: begin
                state_d = ST_HALTED;
            end
            default: begin
                state_d     = ST_RUN;
                drain_cnt_d = 2'd0;
            end
        endcase
    end

    // Stall / bubble outputs, forced inactive while reset is asserted.
    always_comb begin
        stall_F = 1'b0;
        stall_D = 1'b0;
        stall_E = 1'b0;
        nop_D   = 1'b0;
        nop_E   = 1'b0;
        if (RST) begin
            stall_F = 1'b0;
        end else begin
            case (state_q)
                ST_RUN, ST_DRAIN: begin
                    if (flush_s) begin
                        nop_D = 1'b1;
                        nop_E = 1'b1;
                    end else if (state_q == ST_DRAIN) begin
                        stall_F = 1'b1;
                        nop_D   = 1'b1;
                    end else if (load_use_s) begin
                        stall_F = 1'b1;
                        stall_D = 1'b1;
                        nop_E   = 1'b1;
                    end else begin
                        stall_F = 1'b0;
                    end
                end
                ST_HALTED: begin
                    stall_F = 1'b1;
                    stall_D = 1'b1;
                    stall_E = 1'b1;
                end
                default: begin
                    stall_F = 1'b0;
                end
            endcase
        end
    end

    assign FwdA_E     = RST ? FWD_RF : fwd_a_s;
    assign FwdB_E     = RST ? FWD_RF : fwd_b_s;
    assign Halted     = (state_q == ST_HALTED);
    assign StallCount = stall_cnt_q;
    assign FlushCount = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed scenarios plus random traffic.
// A driver applies one input vector per cycle and queues the expected
// response from a behavioural model; a monitor pops and compares.
module tb_pipeline_hazard_ctrl;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [4:0]  Rs1_D = 5'd0, Rs2_D = 5'd0, Rs1_E = 5'd0, Rs2_E = 5'd0;
    logic [4:0]  Rdst_E = 5'd0, Rdst_M = 5'd0, Rdst_W = 5'd0;
    logic        RegWrEn_E = 1'b1, RegWrEn_M = 1'b1, RegWrEn_W = 1'b1;
    logic [1:0]  WBSel_E = 2'd0;
    logic        BranchTaken_E = 1'b0, halt_D = 1'b0;
    logic        stall_F, stall_D, stall_E, nop_D, nop_E, Halted;
    logic [1:0]  FwdA_E, FwdB_E;
    logic [15:0] StallCount, FlushCount;

    typedef struct packed {
        logic       rst;
        logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
        logic       wee, wem, wew;
        logic [1:0] wbsel;
        logic       br, halt;
    } stim_t;

    // ctrl = {stall_F, stall_D, stall_E, nop_D, nop_E, Halted}
    typedef struct {
        int         n;
        logic [5:0] ctrl;
        logic [3:0] fwd;
        logic [31:0] cnt;
    } exp_t;

    exp_t sb_q[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;

    // Model state: halted flag, drain cycles still to go (0 = running), counts.
    bit m_halted     = 1'b0;
    int m_drain_left = 0;
    int m_stall_cnt  = 0;
    int m_flush_cnt  = 0;

    pipeline_hazard_ctrl dut (
        .CLK(CLK), .RST(RST),
        .Rs1_D(Rs1_D), .Rs2_D(Rs2_D), .Rs1_E(Rs1_E), .Rs2_E(Rs2_E),
        .Rdst_E(Rdst_E), .Rdst_M(Rdst_M), .Rdst_W(Rdst_W),
        .RegWrEn_E(RegWrEn_E), .RegWrEn_M(RegWrEn_M), .RegWrEn_W(RegWrEn_W),
        .WBSel_E(WBSel_E), .BranchTaken_E(BranchTaken_E), .halt_D(halt_D),
        .stall_F(stall_F), .stall_D(stall_D), .stall_E(stall_E),
        .nop_D(nop_D), .nop_E(nop_E), .FwdA_E(FwdA_E), .FwdB_E(FwdB_E),
        .Halted(Halted), .StallCount(StallCount), .FlushCount(FlushCount)
    );

    always #5 CLK = ~CLK;

    function automatic stim_t idle();
        stim_t s;
        s     = '0;
        s.wee = 1'b1;
        s.wem = 1'b1;
        s.wew = 1'b1;
        return s;
    endfunction

    function automatic logic [1:0] exp_fwd(input logic [4:0] rs, input stim_t s);
        if (!s.wem && s.rdm != 5'd0 && s.rdm == rs) return 2'b01;
        if (!s.wew && s.rdw != 5'd0 && s.rdw == rs) return 2'b10;
        return 2'b00;
    endfunction

    task automatic apply(input stim_t s);
        RST = s.rst;
        Rs1_D = s.rs1d; Rs2_D = s.rs2d; Rs1_E = s.rs1e; Rs2_E = s.rs2e;
        Rdst_E = s.rde; Rdst_M = s.rdm; Rdst_W = s.rdw;
        RegWrEn_E = s.wee; RegWrEn_M = s.wem; RegWrEn_W = s.wew;
        WBSel_E = s.wbsel; BranchTaken_E = s.br; halt_D = s.halt;
    endtask

    // One cycle: drive, predict, queue, then advance the model past the edge.
    task automatic step(input stim_t s);
        exp_t e;
        bit   lu;
        @(posedge CLK);
        apply(s);
        cyc    = cyc + 1;
        e.n    = cyc;
        e.ctrl = 6'b000000;
        e.fwd  = 4'b0000;
        e.cnt  = 32'd0;
        if (s.rst) begin
            m_halted = 1'b0; m_drain_left = 0; m_stall_cnt = 0; m_flush_cnt = 0;
        end else begin
            e.cnt = {m_stall_cnt[15:0], m_flush_cnt[15:0]};
            e.fwd = {exp_fwd(s.rs1e, s), exp_fwd(s.rs2e, s)};
            lu = (s.wbsel == 2'b01) && !s.wee && (s.rde != 5'd0) &&
                 (s.rde == s.rs1d || s.rde == s.rs2d);
            if (m_halted) begin
                e.ctrl = 6'b111001;
            end else if (s.br) begin
                e.ctrl = 6'b000110;
                if (m_flush_cnt < 65535) m_flush_cnt = m_flush_cnt + 1;
                m_drain_left = 0;
            end else if (m_drain_left > 0) begin
                e.ctrl = 6'b100100;
                m_drain_left = m_drain_left - 1;
                if (m_drain_left == 0) m_halted = 1'b1;
            end else if (lu) begin
                e.ctrl = 6'b110010;
                if (m_stall_cnt < 65535) m_stall_cnt = m_stall_cnt + 1;
            end else if (s.halt) begin
                m_drain_left = 3;
            end
        end
        sb_q.push_back(e);
    endtask

    // Monitor: compare mid-cycle, well away from the falling update edge.
    always @(posedge CLK) begin
        exp_t e;
        logic [5:0]  act_ctrl;
        logic [3:0]  act_fwd;
        logic [31:0] act_cnt;
        #2;
        if (sb_q.size() > 0) begin
            e        = sb_q.pop_front();
            act_ctrl = {stall_F, stall_D, stall_E, nop_D, nop_E, Halted};
            act_fwd  = {FwdA_E, FwdB_E};
            act_cnt  = {StallCount, FlushCount};
            tests = tests + 3;
            if (act_ctrl !== e.ctrl) begin
                fails = fails + 1;
                $display("FAIL ctrl cyc %0d: got %b want %b (stallF,D,E,nopD,E,Halted)", e.n, act_ctrl, e.ctrl);
            end
            if (act_fwd !== e.fwd) begin
                fails = fails + 1;
                $display("FAIL fwd cyc %0d: got %b want %b (FwdA,FwdB)", e.n, act_fwd, e.fwd);
            end
            if (act_cnt !== e.cnt) begin
                fails = fails + 1;
                $display("FAIL counters cyc %0d: got %h want %h (Stall,Flush)", e.n, act_cnt, e.cnt);
            end
        end
    end

    initial begin
        stim_t s;
        stim_t lw;
        // reset state
        s = idle(); s.rst = 1'b1;
        step(s); step(s);
        // Scenario 1: load-use stalls one cycle, then the load moves to M
        lw = idle(); lw.rde = 5'd5; lw.wbsel = 2'b01; lw.wee = 1'b0; lw.rs1d = 5'd5;
        step(lw);
        s = idle(); s.rdm = 5'd5; s.wem = 1'b0; s.rs1e = 5'd5;
        step(s);
        step(idle());
        // Scenario 2: M has priority over W, x0 never forwards
        s = idle(); s.rdm = 5'd7; s.wem = 1'b0; s.rdw = 5'd7; s.wew = 1'b0; s.rs2e = 5'd7;
        step(s);
        s.rdm = 5'd0;
        step(s);
        s.rs1e = 5'd0; s.rdw = 5'd0;
        step(s);
        // Scenario 3: branch overrides concurrent load-use
        s = lw; s.br = 1'b1;
        step(s);
        step(idle());
        // Scenario 4: halt drains for three cycles then stays halted
        s = idle(); s.halt = 1'b1;
        step(s);
        for (int i = 0; i < 8; i++) step(idle());
        s = idle(); s.br = 1'b1;
        step(s);
        // Scenario 5: branch on the second drain cycle cancels the halt
        s = idle(); s.rst = 1'b1;
        step(s);
        s = idle(); s.halt = 1'b1;
        step(s);
        step(idle());
        s = idle(); s.br = 1'b1;
        step(s);
        for (int i = 0; i < 5; i++) step(idle());
        // halt together with load-use: stall first, drain once unstalled
        s = lw; s.halt = 1'b1;
        step(s);
        s = idle(); s.halt = 1'b1;
        step(s);
        for (int i = 0; i < 4; i++) step(idle());
        // Scenario 6: saturate StallCount, then reset mid-drain
        s = idle(); s.rst = 1'b1;
        step(s);
        for (int i = 0; i < 65537; i++) step(lw);
        step(idle());
        s = idle(); s.halt = 1'b1;
        step(s);
        step(idle());
        s = idle(); s.rst = 1'b1; s.rs1e = 5'd3; s.rdm = 5'd3; s.wem = 1'b0; s.br = 1'b1;
        step(s);
        for (int i = 0; i < 4; i++) step(idle());
        // random traffic
        for (int i = 0; i < 3000; i++) begin
            s       = '0;
            s.rst   = ($urandom_range(0, 63) == 0);
            s.rs1d  = 5'($urandom_range(0, 3));
            s.rs2d  = 5'($urandom_range(0, 3));
            s.rs1e  = 5'($urandom_range(0, 3));
            s.rs2e  = 5'($urandom_range(0, 3));
            s.rde   = 5'($urandom_range(0, 3));
            s.rdm   = 5'($urandom_range(0, 3));
            s.rdw   = 5'($urandom_range(0, 3));
            s.wee   = 1'($urandom_range(0, 1));
            s.wem   = 1'($urandom_range(0, 1));
            s.wew   = 1'($urandom_range(0, 1));
            s.wbsel = 2'($urandom_range(0, 3));
            s.br    = ($urandom_range(0, 7) == 0);
            s.halt  = ($urandom_range(0, 19) == 0);
            step(s);
        end
        @(posedge CLK);
        #4;
        tests = tests + 1;
        if (sb_q.size() != 0) begin
            fails = fails + 1;
            $display("FAIL drain: %0d entries left, want 0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
